// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
// Shared definitions for the two-requester mux arbiter:
//   state_e    - arbiter FSM states (IDLE, OWN_A, OWN_B)
//   REQ_A/B    - requester identifiers, also the mux select value
//   BEAT_CNT_W - width of the per-grant beat counter
// Related build macro: MUX_ARB_FIXED_PRIO_EN (selects fixed priority in mux_arb_ctrl).
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/mux_arb_ctrl_mux21.sv
// mux21
// Single-bit 2:1 multiplexer cell used to build the arbiter datapath.
// Ports:
//   a_i - input selected when s_i = 0
//   b_i - input selected when s_i = 1
//   s_i - select
//   y_o - selected output
module mux21 (
    input  logic a_i,
    input  logic b_i,
    input  logic s_i,
    output logic y_o
);

    assign y_o = s_i ? b_i : a_i;

endmodule

// File: rtl/mux_arb_ctrl.sv
// mux_arb_ctrl
// Two-requester burst arbiter feeding one downstream sink. A grant is held
// for a whole burst and released on the beat flagged last, or after
// MAX_BEATS accepted beats, whichever comes first.
// Build macro: MUX_ARB_FIXED_PRIO_EN - when defined, requester A always wins
// a contest; otherwise arbitration is round-robin (A wins the first one).
// Parameters:
//   DATA_W    - payload width per requester
//   MAX_BEATS - beats per grant before a forced release (1..255)
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   a_valid/a_last/a_data/a_ready  - requester A beat channel
//   b_valid/b_last/b_data/b_ready  - requester B beat channel
//   q_valid/q_data/q_ready         - downstream beat channel
//   s                              - mux select (0 = A, 1 = B)
//   gnt_a, gnt_b                   - one-hot ownership indicators
module mux_arb_ctrl #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic              a_last,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic              b_last,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data,
    input  logic              q_ready,
    output logic              s,
    output logic              gnt_a,
    output logic              gnt_b
);

    import mux_arb_pkg::*;

    // Count value of the final beat allowed in one grant.
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BEATS - 1);

    state_e                state_q;
    logic [BEAT_CNT_W-1:0] beatCnt_q;
    logic [BEAT_CNT_W-1:0] beatCnt_d;
    logic                  lastGrant_q;
    logic                  s_q;
    logic                  gntA_q;
    logic                  gntB_q;

    logic                  muxValid;
    logic [DATA_W-1:0]     muxData;
    logic                  owning;
    logic                  xfer;
    logic                  curLast;
    logic                  relNow;
    logic                  grantAny;
    logic                  grantPick;

    // Datapath: one mux cell per payload bit plus one for valid, all steered by s.
    for (genvar i = 0; i < DATA_W; i++) begin : g_dataMux
        mux21 u_dataMux (
            .a_i (a_data[i]),
            .b_i (b_data[i]),
            .s_i (s_q),
            .y_o (muxData[i])
        );
    end

    mux21 u_validMux (
        .a_i (a_valid),
        .b_i (b_valid),
        .s_i (s_q),
        .y_o (muxValid)
    );

    assign owning    = gntA_q | gntB_q;
    assign q_valid   = owning & muxValid;
    assign q_data    = muxData;
    assign a_ready   = gntA_q & q_ready;
    assign b_ready   = gntB_q & q_ready;
    assign s         = s_q;
    assign gnt_a     = gntA_q;
    assign gnt_b     = gntB_q;

    assign xfer      = q_valid & q_ready;
    assign curLast   = (state_q == OWN_B) ? b_last : a_last;
    // Release only on an accepted beat, so a stalled beat never changes owner.
    assign relNow    = xfer & (curLast | (beatCnt_q == LAST_BEAT));
    assign beatCnt_d = beatCnt_q + BEAT_CNT_W'(1);

    // Who gets the next grant, evaluated while idle or on the releasing beat.
    always_comb begin
        grantAny  = 1'b0;
        grantPick = REQ_A;
`ifdef MUX_ARB_FIXED_PRIO_EN
        if (state_q == IDLE || relNow) begin
            grantAny  = a_valid | b_valid;
            grantPick = a_valid ? REQ_A : REQ_B;
        end
`else
        if (state_q == IDLE) begin
            grantAny = a_valid | b_valid;
            if (a_valid && b_valid) begin
                grantPick = (lastGrant_q == REQ_B) ? REQ_A : REQ_B;
            end else begin
                grantPick = a_valid ? REQ_A : REQ_B;
            end
        end else if (relNow) begin
            // Hand straight over to the other side if it is waiting.
            if (state_q == OWN_A) begin
                grantAny  = b_valid;
                grantPick = REQ_B;
            end else begin
                grantAny  = a_valid;
                grantPick = REQ_A;
            end
        end
`endif
    end

    // Ownership FSM with registered select and grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beatCnt_q   <= '0;
            lastGrant_q <= REQ_B;
            s_q         <= 1'b0;
            gntA_q      <= 1'b0;
            gntB_q      <= 1'b0;
        end else if (state_q == IDLE || relNow) begin
            if (relNow) begin
                lastGrant_q <= (state_q == OWN_B) ? REQ_B : REQ_A;
            end
            beatCnt_q <= '0;
            if (grantAny) begin
                state_q <= (grantPick == REQ_B) ? OWN_B : OWN_A;
                s_q     <= grantPick;
                gntA_q  <= (grantPick == REQ_A);
                gntB_q  <= (grantPick == REQ_B);
            end else begin
                state_q <= IDLE;
                gntA_q  <= 1'b0;
                gntB_q  <= 1'b0;
            end
        end else if (xfer) begin
            beatCnt_q <= beatCnt_d;
        end
    end

endmodule
